// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package stack_pkg;

    // Operation decoded from {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to address depth entries; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push or replace.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read of the addressed entry.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with push, pop and replace-top, registered pop
// result with a done pulse, occupancy status and sticky error flags.
module param_lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int            AW      = addr_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    op_e              op;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             done_nxt;
    logic             ovf_set;
    logic             unf_set;

    assign op    = op_e'({push, pop});
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // The read port always points at the top entry; when empty the address
    // is parked at 0 and the visible top is forced to 0.
    assign raddr = empty ? '0 : AW'(count - CW'(1));
    assign top   = empty ? '0 : rdata;

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Decode the requested operation against the full/empty guards.
    always_comb begin
        we        = 1'b0;
        waddr     = '0;
        count_nxt = count;
        dout_nxt  = dout;
        done_nxt  = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    we        = 1'b1;
                    waddr     = AW'(count);
                    count_nxt = count + CW'(1);
                    done_nxt  = 1'b1;
                end else begin
                    ovf_set   = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    dout_nxt  = rdata;
                    count_nxt = count - CW'(1);
                    done_nxt  = 1'b1;
                end else begin
                    unf_set   = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (!empty) begin
                    // Old top leaves through dout while din takes its slot.
                    we        = 1'b1;
                    waddr     = raddr;
                    dout_nxt  = rdata;
                    done_nxt  = 1'b1;
                end else begin
                    // Nothing to pop: the push half still lands in slot 0.
                    we        = 1'b1;
                    waddr     = '0;
                    count_nxt = CW'(1);
                    done_nxt  = 1'b1;
                    unf_set   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Control and result registers; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            dout      <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            dout      <= dout_nxt;
            done      <= done_nxt;
            overflow  <= (overflow  & ~clr_err) | ovf_set;
            underflow <= (underflow & ~clr_err) | unf_set;
        end
    end

endmodule

// File: tb/tb_param_lifo_stack.sv
// Scoreboard bench for param_lifo_stack (WIDTH=8, DEPTH=4).
module tb_param_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             done;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] dout;
        logic             done;
        logic             full;
        logic             empty;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_unf;

    param_lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .clr_err   (clr_err),
        .dout      (dout),
        .done      (done),
        .top       (top),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_underrun", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("count", 32'(count), 32'(e.count));
            check_val("top", 32'(top), 32'(e.top));
            check_val("dout", 32'(dout), 32'(e.dout));
            check_val("done", 32'(done), 32'(e.done));
            check_val("full", 32'(full), 32'(e.full));
            check_val("empty", 32'(empty), 32'(e.empty));
            check_val("overflow", 32'(overflow), 32'(e.ovf));
            check_val("underflow", 32'(underflow), 32'(e.unf));
        end
    endtask

    // Drive one operation, advance the model, then compare after the edge.
    task automatic do_op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        exp_t e;
        logic os;
        logic us;
        @(negedge clk);
        push = p; pop = q; din = d; clr_err = c;
        os = 1'b0; us = 1'b0; e.done = 1'b0;
        if (p && !q) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(d);
                e.done = 1'b1;
            end else begin
                os = 1'b1;
            end
        end else if (!p && q) begin
            if (model_q.size() > 0) begin
                m_dout = model_q.pop_back();
                e.done = 1'b1;
            end else begin
                us = 1'b1;
            end
        end else if (p && q) begin
            if (model_q.size() > 0) begin
                m_dout = model_q.pop_back();
                model_q.push_back(d);
            end else begin
                model_q.push_back(d);
                us = 1'b1;
            end
            e.done = 1'b1;
        end
        m_ovf   = (m_ovf & ~c) | os;
        m_unf   = (m_unf & ~c) | us;
        e.count = CW'(model_q.size());
        e.top   = (model_q.size() > 0) ? model_q[model_q.size() - 1] : '0;
        e.dout  = m_dout;
        e.full  = (model_q.size() == DEPTH);
        e.empty = (model_q.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_count"}, 32'(count), 32'd0);
        check_val({tag, "_dout"}, 32'(dout), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_val({tag, "_unf"}, 32'(underflow), 32'd0);
        check_val({tag, "_empty"}, 32'(empty), 32'd1);
        check_val({tag, "_top"}, 32'(top), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to three entries.
        do_op(1'b1, 1'b0, 8'h11, 1'b0);
        do_op(1'b1, 1'b0, 8'h22, 1'b0);
        do_op(1'b1, 1'b0, 8'h33, 1'b0);
        check_val("fill3_top", 32'(top), 32'h33);

        // Reach full, then a rejected push.
        do_op(1'b1, 1'b0, 8'h44, 1'b0);
        do_op(1'b1, 1'b0, 8'h55, 1'b0);
        check_val("ovf_top", 32'(top), 32'h44);

        // Replace-top from full, then clear the overflow flag.
        do_op(1'b1, 1'b1, 8'hAA, 1'b0);
        check_val("repl_dout", 32'(dout), 32'h44);
        do_op(1'b0, 1'b0, 8'h00, 1'b1);

        // Drain, then one pop too many.
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("pop1_dout", 32'(dout), 32'hAA);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("pop2_dout", 32'(dout), 32'h33);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("pop3_dout", 32'(dout), 32'h22);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("pop4_dout", 32'(dout), 32'h11);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("unf_dout", 32'(dout), 32'h11);

        // Clear, then replace on empty sets underflow but still pushes.
        do_op(1'b0, 1'b0, 8'h00, 1'b1);
        do_op(1'b1, 1'b1, 8'h5C, 1'b0);
        check_val("erepl_top", 32'(top), 32'h5C);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        do_op(1'b0, 1'b0, 8'h00, 1'b1);
        // New underflow in the same cycle as the clear must win.
        do_op(1'b0, 1'b1, 8'h00, 1'b1);
        check_val("clr_vs_err", 32'(underflow), 32'd1);
        do_op(1'b0, 1'b0, 8'h00, 1'b1);

        // Random mix of operations.
        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), ($urandom_range(0, 7) == 0));
        end
        do_op(1'b0, 1'b0, 8'h00, 1'b1);
        while (model_q.size() > 0) begin
            do_op(1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Asynchronous reset with a push pending.
        do_op(1'b1, 1'b0, 8'h01, 1'b0);
        do_op(1'b1, 1'b0, 8'h02, 1'b0);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        do_op(1'b0, 1'b1, 8'h00, 1'b0);
        do_op(1'b1, 1'b0, 8'h01, 1'b0);
        do_op(1'b1, 1'b0, 8'h02, 1'b0);
        @(negedge clk);
        push = 1'b1; pop = 1'b0; din = 8'h99; clr_err = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        model_q.delete();
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_val("arst_hold_count", 32'(count), 32'd0);
        @(negedge clk);
        push = 1'b0;
        rst_n = 1'b1;
        do_op(1'b1, 1'b0, 8'h7E, 1'b0);
        check_val("post_rst_top", 32'(top), 32'h7E);
        check_val("post_rst_count", 32'(count), 32'd1);
        do_op(1'b0, 1'b0, 8'h00, 1'b0);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
